multicycle_control: RTL and testbench
=====================================

# multicycle_control

Control unit for the multicycle RV32I subset (lw, sw, R-type, I-type ALU, beq, jal). It sequences the shared datapath: PC, instruction/data memory, instruction register, ALU and the 32×32 register file. Each cycle it drives the register-file write enable and the datapath mux selects from a Moore state machine plus a combinational ALU decoder. It sits beside the datapath at the core top level.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  instruction opcode, IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete (present only with MC_MEM_WAIT_EN)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  IR/OldPC load enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 (A)
- ALUSrcB  out  2  00=rs2 (WriteData), 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write enable
- illegal  out  1  unsupported opcode trap flag
- state  out  4  current state (debug)

## Operation
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Transitions:
  - FETCH→DECODE.
  - DECODE by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - else → TRAP
  - MEMADR→MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
  - TRAP holds until rst.
- Moore outputs. Unlisted outputs are 0 (ALUOp: 00 add, 01 sub, 10 funct).
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - TRAP: illegal=1, all enables 0.
- PCWrite = PCUpdate | (Branch & zero).
- ImmSrc is combinational from op: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- ALU decoder:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10 by funct3:
    - 000 → sub if op[5]&funct7b5, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - other → add

## Timing
- Reset: state=FETCH immediately (asynchronous). While rst=1, PCWrite, IRWrite, RegWrite and MemWrite are forced 0; illegal=0. Mux selects show FETCH values.
- First fetch occurs on the first rising edge after rst deasserts.
- Cycles per instruction (no wait states): lw 5, sw 4, R/I 4, jal 4, beq 3.
- Reset mid-instruction aborts it. No partial write occurs after rst rises.
- BEQ: PCWrite follows zero in the same cycle, combinationally.

## Configuration
- MC_MEM_WAIT_EN defined:
  - mem_ready input exists.
  - FETCH, MEMREAD and MEMWRITE hold until mem_ready=1.
  - IRWrite and PCWrite in FETCH assert only in the cycle with mem_ready=1.
  - MemWrite stays high for the whole MEMWRITE wait.
- MC_MEM_WAIT_EN undefined: the port is absent and every access completes in one cycle.

## Structure
- Package riscv_pkg: state enum, opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL), ALUControl codes, ImmSrc codes.
- Sub-module alu_decoder: ALUOp, funct3, funct7b5, op[5] → ALUControl. Fully combinational.
- State register and output decode in multicycle_control.

## Test plan
- Reset held 3 cycles, then released with op=0000011 → state 0→1→2→3→4→0; RegWrite=1 only in MEMWB, ResultSrc=01 there.
- op=0110011, funct3=000, funct7b5=1 → EXECUTER with ALUControl=001; ALUWB RegWrite=1; 4 cycles total.
- beq with zero=1 → PCWrite=1 in BEQ. With zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- op=0100011 → MEMWRITE with MemWrite=1, AdrSrc=1, ImmSrc=01, RegWrite never 1.
- op=1111111 → TRAP, illegal=1 sticks for 10 cycles; rst clears it and returns to FETCH.
- With MC_MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH → state stays 0 and IRWrite=0; IRWrite=1 in the mem_ready=1 cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, opcodes,
// ALU operation codes and datapath mux select codes.
package riscv_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OP_W     = 7;
   localparam int unsigned FUNCT3_W = 3;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned ALUCTL_W = 3;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_e;

   localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

   localparam logic [SEL_W-1:0] IMM_I = 2'b00;
   localparam logic [SEL_W-1:0] IMM_S = 2'b01;
   localparam logic [SEL_W-1:0] IMM_B = 2'b10;
   localparam logic [SEL_W-1:0] IMM_J = 2'b11;

   localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
   localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction function fields
// to the ALU operation select.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [ALUOP_W-1:0]  alu_op_i,
   input  logic [FUNCT3_W-1:0] funct3_i,
   input  logic                funct7b5_i,
   input  logic                op5_i,
   output logic [ALUCTL_W-1:0] alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      if (alu_op_i == ALUOP_SUB) begin
         alu_control_o = ALU_SUB;
      end else if (alu_op_i == ALUOP_FUNCT) begin
         case (funct3_i)
            3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control_o = ALU_SLT;
            3'b110:  alu_control_o = ALU_OR;
            3'b111:  alu_control_o = ALU_AND;
            default: alu_control_o = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: Moore sequencer driving datapath selects.
// Define MC_MEM_WAIT_EN to add mem_ready stalls on FETCH/MEMREAD/MEMWRITE.
module multicycle_control
   import riscv_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [OP_W-1:0]     op,
   input  logic [FUNCT3_W-1:0] funct3,
   input  logic                funct7b5,
   input  logic                zero,
`ifdef MC_MEM_WAIT_EN
   input  logic                mem_ready,
`endif
   output logic                PCWrite,
   output logic                AdrSrc,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic [SEL_W-1:0]    ResultSrc,
   output logic [SEL_W-1:0]    ALUSrcA,
   output logic [SEL_W-1:0]    ALUSrcB,
   output logic [SEL_W-1:0]    ImmSrc,
   output logic [ALUCTL_W-1:0] ALUControl,
   output logic                RegWrite,
   output logic                illegal,
   output logic [STATE_W-1:0]  state
);

   state_e               state_q, state_d;
   logic [ALUOP_W-1:0]   alu_op;
   logic                 pc_update;
   logic                 branch;
   logic                 mem_done;

`ifdef MC_MEM_WAIT_EN
   assign mem_done = mem_ready;
`else
   assign mem_done = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Next state and Moore outputs; write enables are squashed while in reset.
   always_comb begin
      state_d   = state_q;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      RegWrite  = 1'b0;
      illegal   = 1'b0;
      alu_op    = ALUOP_ADD;
      pc_update = 1'b0;
      branch    = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            if (mem_done) begin
               IRWrite   = 1'b1;
               pc_update = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_done) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_done) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_TRAP:  illegal = 1'b1;
         default: state_d = S_FETCH;
      endcase
      PCWrite = pc_update | (branch & zero);
      if (rst) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         illegal  = 1'b0;
      end
   end

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = IMM_S;
         OP_BEQ:  ImmSrc = IMM_B;
         OP_JAL:  ImmSrc = IMM_J;
         default: ImmSrc = IMM_I;
      endcase
   end

   assign state = STATE_W'(state_q);

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .funct7b5_i    (funct7b5),
      .op5_i         (op[5]),
      .alu_control_o (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction state-sequence model checked
// every cycle, plus directed hand-computed expectations.
module tb_multicycle_control;

   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_BEQ = 7'b1100011;
   localparam logic [6:0] T_JAL = 7'b1101111;
   localparam logic [6:0] T_BAD = 7'b1111111;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic [1:0] res;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic [2:0] alu;
      logic       regw;
      logic       ill;
   } outs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] op = T_LW;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;

   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   int total = 0;
   int bad = 0;
   int step = 0;
   logic [3:0] cur_s;
   outs_t dut_o;
   outs_t obs [0:15];

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
`ifdef MC_MEM_WAIT_EN
      .mem_ready  (mem_ready),
`endif
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .RegWrite   (RegWrite),
      .illegal    (illegal),
      .state      (state)
   );

   assign dut_o = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Instruction length in cycles; 0 marks an opcode that never completes.
   function automatic int seq_len(input logic [6:0] o);
      case (o)
         T_LW:                      return 5;
         T_SW, T_R, T_I, T_JAL:     return 4;
         T_BEQ:                     return 3;
         default:                   return 0;
      endcase
   endfunction

   function automatic logic [3:0] seq_state(input logic [6:0] o, input int k);
      logic [3:0] lw_seq [0:4];
      lw_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      if (k < 2) return 4'(k);
      case (o)
         T_LW:    return lw_seq[k];
         T_SW:    return 4'd5 - 4'd3 * 4'(k == 2);
         T_R:     return (k == 2) ? 4'd6 : 4'd8;
         T_I:     return (k == 2) ? 4'd7 : 4'd8;
         T_BEQ:   return 4'd9;
         T_JAL:   return (k == 2) ? 4'd10 : 4'd8;
         default: return 4'd11;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic outs_t model(input logic [3:0] s, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z, input logic rdy, input logic r);
      outs_t e;
      e = '0;
      if (r) s = 4'd0;
      e.st  = s;
      e.imm = (o == T_SW) ? 2'b01 : (o == T_BEQ) ? 2'b10 : (o == T_JAL) ? 2'b11 : 2'b00;
      case (s)
         4'd0:  begin e.irw = rdy; e.pcw = rdy; e.sb = 2'b10; e.res = 2'b10; end
         4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
         4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
         4'd3:  e.adr = 1'b1;
         4'd4:  begin e.res = 2'b01; e.regw = 1'b1; end
         4'd5:  begin e.adr = 1'b1; e.memw = 1'b1; end
         4'd6:  begin e.sa = 2'b10; e.alu = funct_alu(o, f3, f7); end
         4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = funct_alu(o, f3, f7); end
         4'd8:  e.regw = 1'b1;
         4'd9:  begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
         4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
         default: e.ill = 1'b1;
      endcase
      if (r) begin
         e.pcw = 1'b0; e.irw = 1'b0; e.regw = 1'b0; e.memw = 1'b0; e.ill = 1'b0;
      end
      return e;
   endfunction

   // Model progress: one step per cycle unless stalled on memory or trapped.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         step <= 0;
      end else begin
         cur_s = seq_state(op, step);
         if (!mem_ready && (cur_s == 4'd0 || cur_s == 4'd3 || cur_s == 4'd5)) step <= step;
         else if (seq_len(op) == 0 && step >= 2) step <= step;
         else if (step + 1 == seq_len(op)) step <= 0;
         else step <= step + 1;
      end
   end

   always @(negedge clk) begin
      chk($sformatf("outs@%0t", $time), 32'(dut_o),
          32'(model(seq_state(op, step), op, funct3, funct7b5, zero, mem_ready, rst)));
   end

   task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input int n);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs[i] = dut_o;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] seq_of(input int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = (v << 4) | 32'(obs[i].st);
      return v;
   endfunction

   function automatic int count_regw(input int n);
      int c;
      c = 0;
      for (int i = 0; i < n; i++) c += int'(obs[i].regw);
      return c;
   endfunction

   initial begin
      int ill_cnt;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_irwrite", 32'(IRWrite), 32'h0);
      chk("rst_pcwrite", 32'(PCWrite), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      run(T_LW, 3'b010, 1'b0, 1'b0, 5);
      chk("lw_seq", seq_of(5), 32'h01234);
      chk("lw_regw_cnt", 32'(count_regw(5)), 32'd1);
      chk("lw_memwb_res", 32'(obs[4].res), 32'h1);

      run(T_R, 3'b000, 1'b1, 1'b0, 4);
      chk("sub_seq", seq_of(4), 32'h0168);
      chk("sub_aluctl", 32'(obs[2].alu), 32'h1);
      chk("sub_regw", 32'(obs[3].regw), 32'h1);

      run(T_BEQ, 3'b000, 1'b0, 1'b1, 3);
      chk("beq_t_seq", seq_of(3), 32'h019);
      chk("beq_t_pcw", 32'(obs[2].pcw), 32'h1);
      run(T_BEQ, 3'b000, 1'b0, 1'b0, 3);
      chk("beq_nt_pcw", 32'(obs[2].pcw), 32'h0);

      run(T_SW, 3'b010, 1'b0, 1'b0, 4);
      chk("sw_seq", seq_of(4), 32'h0125);
      chk("sw_memw", 32'({obs[3].memw, obs[3].adr, obs[3].imm}), 32'h0d);
      chk("sw_regw_cnt", 32'(count_regw(4)), 32'd0);

      run(T_I, 3'b010, 1'b1, 1'b0, 4);
      chk("slti_aluctl", 32'(obs[2].alu), 32'h5);
      run(T_I, 3'b000, 1'b1, 1'b0, 4);
      chk("addi_f7_aluctl", 32'(obs[2].alu), 32'h0);
      run(T_R, 3'b110, 1'b0, 1'b0, 4);
      chk("or_aluctl", 32'(obs[2].alu), 32'h3);

      run(T_JAL, 3'b000, 1'b0, 1'b0, 4);
      chk("jal_seq", seq_of(4), 32'h01a8);
      chk("jal_pcw", 32'(obs[2].pcw), 32'h1);

      // Reset arriving during ALUWB must kill the register write at once.
      op = T_R; funct3 = 3'b111; funct7b5 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_abort_state", 32'(state), 32'h8);
      rst = 1'b1;
      #1;
      chk("abort_state", 32'(state), 32'h0);
      chk("abort_regw", 32'(RegWrite), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      run(T_BAD, 3'b000, 1'b0, 1'b0, 12);
      chk("trap_seq", seq_of(3), 32'h01b);
      ill_cnt = 0;
      for (int i = 2; i < 12; i++) ill_cnt += int'(obs[i].ill);
      chk("trap_ill_cnt", 32'(ill_cnt), 32'd10);
      rst = 1'b1;
      #1;
      chk("trap_clr_ill", 32'(illegal), 32'h0);
      chk("trap_clr_state", 32'(state), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      op = T_LW;

`ifdef MC_MEM_WAIT_EN
      mem_ready = 1'b0;
      op = T_SW; funct3 = 3'b010;
      repeat (3) begin
         @(negedge clk);
         chk("wait_state", 32'(state), 32'h0);
         chk("wait_irw", 32'(IRWrite), 32'h0);
      end
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("ready_irw", 32'(IRWrite), 32'h1);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
      mem_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("wait_memw", 32'({state, MemWrite}), 32'h0b);
      end
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
`endif

      run(T_LW, 3'b010, 1'b0, 1'b0, 5);
      chk("final_lw_seq", seq_of(5), 32'h01234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
